// File: rtl/pulse_wave_gen.sv
// Pulse/square oscillator: phase accumulator, duty/amplitude compare, valid/ready sample stream.
// Optional hard sync input enabled by defining PULSE_WAVE_GEN_SYNC_EN.
module pulse_wave_gen #(
  parameter int width_p       = 12,
  parameter int phase_width_p = 16,
  parameter int duty_width_p  = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
`ifdef PULSE_WAVE_GEN_SYNC_EN
  input  logic                     sync_i,
`endif
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [phase_width_p-1:0] cfg_ftw_i,
  input  logic [duty_width_p-1:0]  cfg_duty_i,
  input  logic [width_p-2:0]       cfg_amp_i,
  output logic [width_p-1:0]       data_o,
  output logic                     valid_o,
  input  logic                     ready_i
);

  logic [phase_width_p-1:0] acc_q;
  logic [phase_width_p-1:0] ftw_q;
  logic [duty_width_p-1:0]  duty_q;
  logic [width_p-2:0]       amp_q;

  logic [phase_width_p-1:0] pend_ftw;
  logic [duty_width_p-1:0]  pend_duty;
  logic [width_p-2:0]       pend_amp;
  logic                     pend_v;

  logic                     sync_w;
  logic                     load;
  logic                     wrap;
  logic [phase_width_p-1:0] acc_sum;
  logic                     high_phase;
  logic [width_p-1:0]       amp_ext;
  logic [width_p-1:0]       sample;
  logic                     apply;
  logic                     cfg_fire;

`ifdef PULSE_WAVE_GEN_SYNC_EN
  assign sync_w = sync_i;
`else
  assign sync_w = 1'b0;
`endif

  assign load = !valid_o || ready_i;
  assign {wrap, acc_sum} = {1'b0, acc_q} + {1'b0, ftw_q};

  assign high_phase = acc_q[phase_width_p-1 -: duty_width_p] < duty_q;
  assign amp_ext    = {1'b0, amp_q};
  assign sample     = high_phase ? amp_ext : -amp_ext;

  // A stalled oscillator (ftw 0) never wraps, so it takes new settings immediately.
  assign apply       = pend_v && ((load && wrap) || (ftw_q == '0) || sync_w);
  assign cfg_fire    = cfg_valid_i && !pend_v;
  assign cfg_ready_o = !pend_v;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q     <= '0;
      ftw_q     <= '0;
      duty_q    <= {1'b1, {(duty_width_p-1){1'b0}}};
      amp_q     <= '0;
      pend_ftw  <= '0;
      pend_duty <= '0;
      pend_amp  <= '0;
      pend_v    <= 1'b0;
      data_o    <= '0;
      valid_o   <= 1'b0;
    end else begin
      if (load) begin
        data_o  <= sample;
        valid_o <= 1'b1;
        acc_q   <= acc_sum;
      end
      if (sync_w) begin
        acc_q <= '0;
      end
      if (apply) begin
        ftw_q  <= pend_ftw;
        duty_q <= pend_duty;
        amp_q  <= pend_amp;
        pend_v <= 1'b0;
      end else if (cfg_fire) begin
        pend_ftw  <= cfg_ftw_i;
        pend_duty <= cfg_duty_i;
        pend_amp  <= cfg_amp_i;
        pend_v    <= 1'b1;
      end
    end
  end

endmodule
